// File: rtl/seq_div_32by16_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned DIV_DW = 32;
  localparam int unsigned DIV_VW = 16;

  // Quotient reported for a zero divisor; the top truncates it to its own DW.
  localparam logic [63:0] DIV_BY_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/seq_div_32by16_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference when it does not go negative.
module div_step #(
  parameter int unsigned VW = 16
) (
  input  logic [VW:0]   p_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   p_o,
  output logic          q_bit_o
);

  logic [VW:0] p_shift;
  logic [VW:0] trial;

  // The partial remainder stays below the divisor, so its top bit is always zero.
  logic unused_p_msb;
  assign unused_p_msb = p_i[VW];

  always_comb begin
    p_shift = {p_i[VW-1:0], q_msb_i};
    trial   = p_shift - {1'b0, d_i};
    q_bit_o = ~trial[VW];
    p_o     = q_bit_o ? trial : p_shift;
  end

endmodule

// File: rtl/seq_div_32by16.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// Define SEQ_DIV_EARLY_TERM_EN to skip the leading zeros of the dividend.
module seq_div_32by16
  import seq_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW,
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  div_state_e    state_q, state_d;
  logic [VW:0]   p_q, p_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_p;
  logic          step_bit;

  div_step #(
    .VW (VW)
  ) u_div_step (
    .p_i     (p_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .p_o     (step_p),
    .q_bit_o (step_bit)
  );

`ifdef SEQ_DIV_EARLY_TERM_EN
  // Number of significant dividend bits; a zero dividend still takes one step.
  logic [CW-1:0] lead_len;
  logic [CW-1:0] lead_shamt;

  always_comb begin
    lead_len = CW'(1);
    for (int i = 0; i < DW; i++) begin
      if (dividend[i]) begin
        lead_len = CW'(i + 1);
      end
    end
    lead_shamt = CW'(DW) - lead_len;
  end
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d = StDone;
            q_d     = DW'(DIV_BY_ZERO_QUOT);
            p_d     = {1'b0, dividend[VW-1:0]};
            dbz_d   = 1'b1;
          end else begin
            state_d = StCalc;
            p_d     = '0;
            d_d     = divisor;
            dbz_d   = 1'b0;
`ifdef SEQ_DIV_EARLY_TERM_EN
            q_d     = dividend << lead_shamt;
            cnt_d   = lead_len;
`else
            q_d     = dividend;
            cnt_d   = CW'(DW);
`endif
          end
        end
      end
      StCalc: begin
        p_d   = step_p;
        q_d   = {q_q[DW-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign quotient    = q_q;
  assign remainder   = p_q[VW-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_32by16.sv
// Self-checking bench for seq_div_32by16: directed cases plus randomized traffic
// compared every cycle against a plain-arithmetic model.
module tb_seq_div_32by16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  seq_div_32by16 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit init_done = 1'b0;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic [31:0] dvd;
    logic [15:0] dvs;
    int          acc;
    int          lat;
  } exp_t;

  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from the accepting edge until out_valid is visible.
  function automatic int lat_of(input logic [31:0] a, input logic [15:0] b);
    int l;
    l = 32;
    if (b == 16'd0) return 0;
`ifdef SEQ_DIV_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 32; i++) if (a[i]) l = i + 1;
`endif
    return l;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int acc);
    exp_t e;
    e.dvd = a;
    e.dvs = b;
    e.acc = acc;
    e.lat = lat_of(a, b);
    if (b == 16'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a[15:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = a / {16'd0, b};
      e.r   = 16'(a % {16'd0, b});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Single compare process: checks handshake and result every cycle.
  exp_t        cur;
  bit          exp_ov;
  logic [63:0] recon;
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
    end else if (init_done) begin
      chk("in_ready", 64'(in_ready), 64'(expq.size() == 0));
      exp_ov = 1'b0;
      if (expq.size() > 0) begin
        cur    = expq[0];
        exp_ov = (cyc >= cur.acc + 1 + cur.lat);
      end
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) begin
        chk("quotient", 64'(quotient), 64'(cur.q));
        chk("remainder", 64'(remainder), 64'(cur.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(cur.dbz));
        if (!cur.dbz) begin
          recon = 64'(quotient) * 64'(cur.dvs) + 64'(remainder);
          chk("q*d+r", recon, 64'(cur.dvd));
          chk("r<d", 64'(remainder < cur.dvs), 64'd1);
        end
        if (out_ready) void'(expq.pop_front());
      end
      if (in_valid && in_ready) expq.push_back(model(dividend, divisor, cyc));
    end
  end

  task automatic issue(input logic [31:0] a, input logic [15:0] b, input int hold,
                       output logic [31:0] q, output logic [15:0] r, output logic z,
                       output int lat);
    bit ok;
    q   = '0;
    r   = '0;
    z   = 1'b0;
    lat = 0;
    @(posedge clk);
    #1;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!ok) chk("result_timeout", 64'(out_valid), 64'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        in_valid = i[0];
        dividend = $urandom;
        divisor  = 16'($urandom);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  logic [31:0] rq;
  logic [15:0] rr;
  logic        rz;
  int          rl;
  logic [31:0] ra;
  logic [15:0] rb;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);

    issue(32'd1000, 16'd7, 0, rq, rr, rz, rl);
    chk("1000/7 q", 64'(rq), 64'd142);
    chk("1000/7 r", 64'(rr), 64'd6);
    chk("1000/7 dbz", 64'(rz), 64'd0);
`ifdef SEQ_DIV_EARLY_TERM_EN
    chk("1000/7 latency", 64'(rl), 64'd10);
`else
    chk("1000/7 latency", 64'(rl), 64'd32);
`endif

    issue(32'hFFFE_0001, 16'hFFFF, 0, rq, rr, rz, rl);
    chk("sq q", 64'(rq), 64'h0000_FFFF);
    chk("sq r", 64'(rr), 64'd0);
    issue(32'hFFFF_FFFF, 16'hFFFF, 0, rq, rr, rz, rl);
    chk("max q", 64'(rq), 64'h0001_0001);
    chk("max r", 64'(rr), 64'd0);

    issue(32'h1234_5678, 16'd0, 0, rq, rr, rz, rl);
    chk("dbz flag", 64'(rz), 64'd1);
    chk("dbz q", 64'(rq), 64'hFFFF_FFFF);
    chk("dbz r", 64'(rr), 64'h5678);
    chk("dbz latency", 64'(rl), 64'd0);

    // Result held with out_ready low; junk in_valid pulses must be ignored.
    issue(32'd1000, 16'd7, 5, rq, rr, rz, rl);
    chk("hold q", 64'(rq), 64'd142);
    @(negedge clk);
    chk("post_hold in_ready", 64'(in_ready), 64'd1);
    chk("post_hold out_valid", 64'(out_valid), 64'd0);
    chk("post_hold q retained", 64'(quotient), 64'd142);
    chk("post_hold r retained", 64'(remainder), 64'd6);

    // Reset during the 10th CALC cycle discards the division.
    @(posedge clk);
    #1;
    dividend  = 32'h00AB_CDEF;
    divisor   = 16'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst quotient", 64'(quotient), 64'd0);
    chk("mid_rst remainder", 64'(remainder), 64'd0);
    chk("mid_rst dbz", 64'(div_by_zero), 64'd0);
    issue(32'd100, 16'd3, 0, rq, rr, rz, rl);
    chk("100/3 q", 64'(rq), 64'd33);
    chk("100/3 r", 64'(rr), 64'd1);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = 16'($urandom_range(1, 65535));
      if (n % 4 == 0) rb = rb >> $urandom_range(0, 15);
      if (rb == 16'd0) rb = 16'd1;
      issue(ra, rb, 0, rq, rr, rz, rl);
    end

    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
